// File: rtl/alu_issue_if.sv
// Issue-stage bundle interface: upstream decode fields in, registered ALU bundle out.
// valid/ready: a transfer happens on a clock edge where valid and ready are both 1; valid never waits on ready, and payload holds while valid=1 and ready=0.
interface alu_issue_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int TAG_WIDTH     = 5
);
  logic                     in_valid;
  logic                     in_ready;
  logic [1:0]               ALUOp;
  logic [2:0]               Funct3;
  logic [6:0]               Funct7;
  logic [DATA_WIDTH-1:0]    in_srca;
  logic [DATA_WIDTH-1:0]    in_srcb;
  logic [TAG_WIDTH-1:0]     in_tag;
  logic                     out_valid;
  logic                     out_ready;
  logic [OPCODE_LENGTH-1:0] Operation;
  logic [DATA_WIDTH-1:0]    SrcA;
  logic [DATA_WIDTH-1:0]    SrcB;
  logic [TAG_WIDTH-1:0]     out_tag;
  logic                     illegal;
  logic                     trap;

  modport master (
    output in_valid, ALUOp, Funct3, Funct7, in_srca, in_srcb, in_tag, out_ready,
    input  in_ready, out_valid, Operation, SrcA, SrcB, out_tag, illegal, trap
  );

  modport slave (
    input  in_valid, ALUOp, Funct3, Funct7, in_srca, in_srcb, in_tag, out_ready,
    output in_ready, out_valid, Operation, SrcA, SrcB, out_tag, illegal, trap
  );
endinterface

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes ALUOp/Funct3/Funct7, registers operands, 2-entry skid buffer.
// Optional ALU_ISSUE_ILLEGAL_TRAP_EN: swallow illegal bundles and raise a sticky trap.
module alu_issue_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int TAG_WIDTH     = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  alu_issue_if.slave bus,
  output logic [1:0] skid_state
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  localparam logic [3:0] OP_ILLEGAL = 4'b1111;

  typedef struct packed {
    logic [OPCODE_LENGTH-1:0] op;
    logic [DATA_WIDTH-1:0]    a;
    logic [DATA_WIDTH-1:0]    b;
    logic [TAG_WIDTH-1:0]     tag;
    logic                     ill;
  } entry_t;

  logic [1:0] state;
  logic       rdy;
  entry_t     out_q;
  entry_t     skid_q;
  entry_t     in_entry;
  logic [3:0] dec_op;
  logic       dec_ill;
  logic       drop;
  logic       push;
  logic       pop;
  logic       out_valid;

  always_comb begin
    dec_op  = OP_ILLEGAL;
    dec_ill = 1'b1;
    case (bus.ALUOp)
      2'b00: begin
        dec_op  = 4'b0010;
        dec_ill = 1'b0;
      end
      2'b01: begin
        dec_ill = 1'b0;
        case (bus.Funct3)
          3'b000, 3'b001: dec_op = 4'b1000;
          3'b100, 3'b101: dec_op = 4'b1001;
          3'b110, 3'b111: dec_op = 4'b1010;
          default: begin
            dec_op  = OP_ILLEGAL;
            dec_ill = 1'b1;
          end
        endcase
      end
      2'b10: begin
        if (bus.Funct7 == 7'b0000000) begin
          dec_ill = 1'b0;
          case (bus.Funct3)
            3'b000:  dec_op = 4'b0010;
            3'b001:  dec_op = 4'b0101;
            3'b010:  dec_op = 4'b1001;
            3'b011:  dec_op = 4'b1010;
            3'b100:  dec_op = 4'b0100;
            3'b101:  dec_op = 4'b0110;
            3'b110:  dec_op = 4'b0011;
            default: dec_op = 4'b0000;
          endcase
        end else if (bus.Funct7 == 7'b0100000) begin
          // Only SUB and SRA have an alternate funct7 encoding
          if (bus.Funct3 == 3'b000) begin
            dec_op  = 4'b0001;
            dec_ill = 1'b0;
          end else if (bus.Funct3 == 3'b101) begin
            dec_op  = 4'b0111;
            dec_ill = 1'b0;
          end
        end
      end
      default: begin
        dec_ill = 1'b0;
        case (bus.Funct3)
          3'b000: dec_op = 4'b0010;
          3'b010: dec_op = 4'b1001;
          3'b011: dec_op = 4'b1010;
          3'b100: dec_op = 4'b0100;
          3'b110: dec_op = 4'b0011;
          3'b111: dec_op = 4'b0000;
          3'b001: begin
            if (bus.Funct7 == 7'b0000000) dec_op = 4'b0101;
            else dec_ill = 1'b1;
          end
          default: begin
            if (bus.Funct7 == 7'b0000000) dec_op = 4'b0110;
            else if (bus.Funct7 == 7'b0100000) dec_op = 4'b0111;
            else dec_ill = 1'b1;
          end
        endcase
      end
    endcase
  end

  always_comb begin
    in_entry.op  = dec_op;
    in_entry.a   = bus.in_srca;
    in_entry.b   = bus.in_srcb;
    in_entry.tag = bus.in_tag;
    in_entry.ill = dec_ill;
  end

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  assign drop = dec_ill;
`else
  assign drop = 1'b0;
`endif

  assign out_valid = (state != EMPTY);
  assign push      = bus.in_valid & rdy & ~drop;
  assign pop       = out_valid & bus.out_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= EMPTY;
      rdy    <= 1'b1;
      out_q  <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state <= EMPTY;
      rdy   <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            out_q <= in_entry;
            state <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            out_q <= in_entry;
          end else if (push) begin
            skid_q <= in_entry;
            state  <= FULL;
            rdy    <= 1'b0;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            out_q <= skid_q;
            state <= ONE;
            rdy   <= 1'b1;
          end
        end
        default: begin
          state <= EMPTY;
          rdy   <= 1'b1;
        end
      endcase
    end
  end

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  logic trap_q;
  always_ff @(posedge clk) begin
    if (!reset) trap_q <= 1'b0;
    else if (flush) trap_q <= 1'b0;
    else if (bus.in_valid && rdy && dec_ill) trap_q <= 1'b1;
  end
  assign bus.trap    = trap_q;
  assign bus.illegal = 1'b0;
`else
  assign bus.trap    = 1'b0;
  assign bus.illegal = out_q.ill;
`endif

  assign bus.in_ready  = rdy;
  assign bus.out_valid = out_valid;
  assign bus.Operation = out_q.op;
  assign bus.SrcA      = out_q.a;
  assign bus.SrcB      = out_q.b;
  assign bus.out_tag   = out_q.tag;
  assign skid_state    = state;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode table, skid/backpressure ordering, flush, reset.
// Build with ALU_ISSUE_ILLEGAL_TRAP_EN defined to exercise the trap variant.
module tb_alu_issue_stage;

  localparam int DW = 32;
  localparam int OL = 4;
  localparam int TW = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       flush = 1'b0;
  logic [1:0] skid_state;

  int vectors = 0;
  int miscompares = 0;

  logic [OL+TW-1:0] exp_q[$];

  alu_issue_if #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OL), .TAG_WIDTH(TW)) bus ();

  alu_issue_stage #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OL), .TAG_WIDTH(TW)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .bus        (bus),
    .skid_state (skid_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] aluop, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [TW-1:0] tag);
    bus.in_valid = v;
    bus.ALUOp    = aluop;
    bus.Funct3   = f3;
    bus.Funct7   = f7;
    bus.in_srca  = a;
    bus.in_srcb  = b;
    bus.in_tag   = tag;
  endtask

  // single transaction with an idle output: bundle visible one cycle after accept
  task automatic send_one(input string name, input logic [1:0] aluop, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [TW-1:0] tag, input logic [3:0] exp_op, input logic exp_ill);
    bus.out_ready = 1'b1;
    drive(1'b1, aluop, f3, f7, a, b, tag);
    step();
    bus.in_valid = 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    if (exp_ill) begin
      check({name, ".valid"}, 64'(bus.out_valid), 64'd0);
      check({name, ".trap"}, 64'(bus.trap), 64'd1);
    end else begin
      check({name, ".valid"}, 64'(bus.out_valid), 64'd1);
      check({name, ".op"}, 64'(bus.Operation), 64'(exp_op));
      check({name, ".ill"}, 64'(bus.illegal), 64'd0);
      check({name, ".a"}, 64'(bus.SrcA), 64'(a));
      check({name, ".b"}, 64'(bus.SrcB), 64'(b));
      check({name, ".tag"}, 64'(bus.out_tag), 64'(tag));
    end
`else
    check({name, ".valid"}, 64'(bus.out_valid), 64'd1);
    check({name, ".op"}, 64'(bus.Operation), 64'(exp_op));
    check({name, ".ill"}, 64'(bus.illegal), 64'(exp_ill));
    check({name, ".a"}, 64'(bus.SrcA), 64'(a));
    check({name, ".b"}, 64'(bus.SrcB), 64'(b));
    check({name, ".tag"}, 64'(bus.out_tag), 64'(tag));
    check({name, ".trap"}, 64'(bus.trap), 64'd0);
`endif
    step();
    check({name, ".drain"}, 64'(bus.out_valid), 64'd0);
  endtask

  // {ALUOp, Funct3, Funct7, expected Operation, expected illegal}
  logic [16:0] vec [18];

  initial begin
    int accept_iter;
    int iter;
    logic [16:0] v;
    logic [OL+TW-1:0] e;

    vec = '{
      {2'b00, 3'b010, 7'h00, 4'b0010, 1'b0},
      {2'b10, 3'b000, 7'h00, 4'b0010, 1'b0},
      {2'b10, 3'b000, 7'h20, 4'b0001, 1'b0},
      {2'b10, 3'b001, 7'h00, 4'b0101, 1'b0},
      {2'b10, 3'b010, 7'h00, 4'b1001, 1'b0},
      {2'b10, 3'b011, 7'h00, 4'b1010, 1'b0},
      {2'b10, 3'b101, 7'h20, 4'b0111, 1'b0},
      {2'b10, 3'b110, 7'h00, 4'b0011, 1'b0},
      {2'b10, 3'b001, 7'h20, 4'b1111, 1'b1},
      {2'b11, 3'b000, 7'h7f, 4'b0010, 1'b0},
      {2'b11, 3'b100, 7'h15, 4'b0100, 1'b0},
      {2'b11, 3'b001, 7'h20, 4'b1111, 1'b1},
      {2'b11, 3'b101, 7'h01, 4'b1111, 1'b1},
      {2'b01, 3'b000, 7'h00, 4'b1000, 1'b0},
      {2'b01, 3'b101, 7'h00, 4'b1001, 1'b0},
      {2'b01, 3'b110, 7'h00, 4'b1010, 1'b0},
      {2'b01, 3'b010, 7'h00, 4'b1111, 1'b1},
      {2'b10, 3'b111, 7'h01, 4'b1111, 1'b1}
    };

    bus.out_ready = 1'b0;
    drive(1'b0, 2'b00, 3'b000, 7'h00, '0, '0, '0);

    // reset state
    reset = 1'b0;
    step();
    step();
    check("rst.valid", 64'(bus.out_valid), 64'd0);
    check("rst.ready", 64'(bus.in_ready), 64'd1);
    check("rst.op", 64'(bus.Operation), 64'd0);
    check("rst.a", 64'(bus.SrcA), 64'd0);
    check("rst.b", 64'(bus.SrcB), 64'd0);
    check("rst.tag", 64'(bus.out_tag), 64'd0);
    check("rst.ill", 64'(bus.illegal), 64'd0);
    check("rst.trap", 64'(bus.trap), 64'd0);
    check("rst.state", 64'(skid_state), 64'd0);
    reset = 1'b1;

    // SUB with output stalled: appears the cycle after accept
    drive(1'b1, 2'b10, 3'b000, 7'b0100000, 32'd7, 32'd3, 5'd5);
    step();
    bus.in_valid = 1'b0;
    check("sub.valid", 64'(bus.out_valid), 64'd1);
    check("sub.op", 64'(bus.Operation), 64'b0001);
    check("sub.a", 64'(bus.SrcA), 64'd7);
    check("sub.b", 64'(bus.SrcB), 64'd3);
    check("sub.tag", 64'(bus.out_tag), 64'd5);
    check("sub.ill", 64'(bus.illegal), 64'd0);
    step();
    check("sub.hold", 64'(bus.Operation), 64'b0001);
    bus.out_ready = 1'b1;
    step();
    check("sub.drain", 64'(bus.out_valid), 64'd0);

    // back-to-back SRAI then SRLI at full throughput
    drive(1'b1, 2'b11, 3'b101, 7'b0100000, 32'h80, 32'd2, 5'd9);
    step();
    check("b2b.op0", 64'(bus.Operation), 64'b0111);
    check("b2b.rdy0", 64'(bus.in_ready), 64'd1);
    drive(1'b1, 2'b11, 3'b101, 7'b0000000, 32'h81, 32'd3, 5'd10);
    step();
    bus.in_valid = 1'b0;
    check("b2b.op1", 64'(bus.Operation), 64'b0110);
    check("b2b.tag1", 64'(bus.out_tag), 64'd10);
    check("b2b.rdy1", 64'(bus.in_ready), 64'd1);
    step();
    check("b2b.drain", 64'(bus.out_valid), 64'd0);

    // backpressure: ADD, XOR, AND with the skid buffer filling up
    bus.out_ready = 1'b0;
    exp_q = {};
    drive(1'b1, 2'b00, 3'b010, 7'h00, 32'd1, 32'd1, 5'd1);
    exp_q.push_back({4'b0010, 5'd1});
    step();
    check("bp.rdy1", 64'(bus.in_ready), 64'd1);
    drive(1'b1, 2'b10, 3'b100, 7'h00, 32'd2, 32'd2, 5'd2);
    exp_q.push_back({4'b0100, 5'd2});
    step();
    check("bp.rdy2", 64'(bus.in_ready), 64'd0);
    check("bp.state", 64'(skid_state), 64'd2);
    check("bp.hold_op", 64'(bus.Operation), 64'b0010);
    drive(1'b1, 2'b10, 3'b111, 7'h00, 32'd3, 32'd3, 5'd3);
    step();
    check("bp.rdy3", 64'(bus.in_ready), 64'd0);
    check("bp.hold_op2", 64'(bus.Operation), 64'b0010);
    check("bp.hold_tag", 64'(bus.out_tag), 64'd1);
    exp_q.push_back({4'b0000, 5'd3});
    bus.out_ready = 1'b1;
    accept_iter = -1;
    iter = 0;
    while (exp_q.size() != 0 && iter < 12) begin
      logic accepting;
      accepting = bus.in_valid & bus.in_ready;
      if (accepting) accept_iter = iter;
      if (bus.out_valid) begin
        e = exp_q.pop_front();
        check("bp.order", 64'({bus.Operation, bus.out_tag}), 64'(e));
      end
      step();
      if (accepting) bus.in_valid = 1'b0;
      iter++;
    end
    check("bp.remaining", 64'(exp_q.size()), 64'd0);
    check("bp.accept_cycle", 64'(accept_iter), 64'd1);
    check("bp.drain", 64'(bus.out_valid), 64'd0);

    // decode table
    foreach (vec[i]) begin
      v = vec[i];
      send_one($sformatf("dec%0d", i), v[16:15], v[14:12], v[11:5],
               32'h100 + 32'(i), 32'hA5A50000 + 32'(i), 5'(i), v[4:1], v[0]);
    end
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    check("trap.sticky", 64'(bus.trap), 64'd1);
`endif

    // flush while FULL with a same-cycle input
    bus.out_ready = 1'b0;
    drive(1'b1, 2'b00, 3'b000, 7'h00, 32'd10, 32'd10, 5'd10);
    step();
    drive(1'b1, 2'b00, 3'b000, 7'h00, 32'd11, 32'd11, 5'd11);
    step();
    check("fl.full", 64'(skid_state), 64'd2);
    drive(1'b1, 2'b00, 3'b000, 7'h00, 32'd12, 32'd12, 5'd12);
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("fl.valid", 64'(bus.out_valid), 64'd0);
    check("fl.ready", 64'(bus.in_ready), 64'd1);
    check("fl.state", 64'(skid_state), 64'd0);
    check("fl.trap", 64'(bus.trap), 64'd0);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("fl.quiet", 64'(bus.out_valid), 64'd0);
    end

    // flush while ONE with an acceptable same-cycle input
    bus.out_ready = 1'b0;
    drive(1'b1, 2'b00, 3'b000, 7'h00, 32'd13, 32'd13, 5'd13);
    step();
    drive(1'b1, 2'b00, 3'b000, 7'h00, 32'd14, 32'd14, 5'd14);
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("fl1.valid", 64'(bus.out_valid), 64'd0);
    check("fl1.state", 64'(skid_state), 64'd0);

    // reset mid-transaction
    drive(1'b1, 2'b00, 3'b000, 7'h00, 32'd15, 32'd15, 5'd15);
    step();
    bus.in_valid = 1'b0;
    check("mr.valid_before", 64'(bus.out_valid), 64'd1);
    reset = 1'b0;
    step();
    check("mr.valid", 64'(bus.out_valid), 64'd0);
    check("mr.ready", 64'(bus.in_ready), 64'd1);
    check("mr.tag", 64'(bus.out_tag), 64'd0);
    reset = 1'b1;
    bus.out_ready = 1'b1;
    step();
    check("mr.quiet", 64'(bus.out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Execute-side issue stage that produces the ALU's operation code and operands.
- Decodes ALUOp/Funct3/Funct7 into the 4-bit Operation encoding and captures SrcA/SrcB and destination tag.
- Delivers one registered bundle per transaction to the ALU over a valid/ready handshake.
- Contains a 2-entry skid buffer so in_ready is a registered signal and throughput is 1/cycle under continuous out_ready.

Parameters:
- DATA_WIDTH, 32, operand width.
- OPCODE_LENGTH, 4, Operation width; decode table is fixed to 4 bits.
- TAG_WIDTH, 5, destination register tag width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- flush  in  1  synchronous pipeline flush; discards all held entries.
- in_valid  in  1  upstream bundle valid.
- in_ready  out  1  stage can accept; registered.
- ALUOp  in  2  00 load/store, 01 branch, 10 R-type, 11 I-type ALU.
- Funct3  in  3  instruction funct3.
- Funct7  in  7  instruction funct7 (imm[11:5] for I-type).
- in_srca  in  DATA_WIDTH  operand A.
- in_srcb  in  DATA_WIDTH  operand B (register or immediate).
- in_tag  in  TAG_WIDTH  destination tag.
- out_valid  out  1  bundle valid to ALU.
- out_ready  in  1  ALU/writeback accepts.
- Operation  out  OPCODE_LENGTH  decoded ALU operation.
- SrcA  out  DATA_WIDTH  registered operand A.
- SrcB  out  DATA_WIDTH  registered operand B.
- out_tag  out  TAG_WIDTH  registered tag.
- illegal  out  1  bundle carries an undecodable operation.
- trap  out  1  sticky illegal indicator (see Optional Feature).

Behaviour:
- Reset (reset=0 at clk edge): out_valid=0, in_ready=1, Operation=0, SrcA=0, SrcB=0, out_tag=0, illegal=0, trap=0, skid empty.
- Decode happens combinationally on the input side; the result is registered with the operands.
- Decode table:
  - ALUOp 00: ADD=0010.
  - ALUOp 01, by Funct3: 000/001 -> 1000; 100/101 -> 1001; 110/111 -> 1010; 010/011 -> illegal.
  - ALUOp 10, by Funct3/Funct7:
    - 000: 0000000 -> 0010, 0100000 -> 0001.
    - 001: 0000000 -> 0101.
    - 010: 0000000 -> 1001.
    - 011: 0000000 -> 1010.
    - 100: 0000000 -> 0100.
    - 101: 0000000 -> 0110, 0100000 -> 0111.
    - 110: 0000000 -> 0011.
    - 111: 0000000 -> 0000.
    - Any other Funct7 -> illegal.
  - ALUOp 11, by Funct3:
    - 000 -> 0010, 010 -> 1001, 011 -> 1010, 100 -> 0100, 110 -> 0011, 111 -> 0000; Funct7 ignored for these.
    - 001: Funct7=0000000 -> 0101, else illegal.
    - 101: 0000000 -> 0110, 0100000 -> 0111, else illegal.
  - Illegal: Operation=1111, illegal=1.
- Handshake:
  - Input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
  - Output payload is stable while out_valid=1 and out_ready=0.
- Skid buffer (states EMPTY, ONE, FULL):
  - EMPTY: accept -> ONE.
  - ONE: accept with no drain -> FULL; drain with no accept -> EMPTY; both -> ONE, new data loaded directly.
  - FULL: in_ready=0; drain -> ONE, skid entry moves to output.
- Latency: accepted bundle appears on the outputs the cycle after acceptance when the output is empty.
- Ordering is strictly FIFO.
- flush: next cycle out_valid=0, state EMPTY, in_ready=1. A same-cycle input is discarded. flush has priority over all handshakes; reset has priority over flush.
- Reset mid-transaction drops all entries with no partial output.

Optional Feature:
- Macro: ALU_ISSUE_ILLEGAL_TRAP_EN.
- Defined:
  - Illegal bundles are accepted but never presented on the output; they are consumed silently.
  - trap rises the cycle after acceptance and holds until reset or flush.
  - illegal output is tied 0.
- Undefined:
  - Illegal bundles are forwarded with Operation=1111, illegal=1; the ALU default yields 0.
  - trap is tied 0.

Test Plan:
- Reset, then ALUOp=10, F3=000, F7=0100000, A=7, B=3, tag=5 -> next cycle out_valid=1, Operation=0001, SrcA=7, SrcB=3, out_tag=5, illegal=0.
- Back-to-back I-type F3=101 with F7=0100000 then F7=0000000, out_ready=1 -> consecutive cycles Operation=0111 then 0110; in_ready stays 1.
- out_ready=0, push 3 bundles (ADD, XOR, AND):
  - After 2 accepts, in_ready=0 and outputs hold ADD.
  - Release out_ready -> ADD, XOR, AND delivered in order.
  - Third bundle accepted exactly when in_ready returns to 1.
- ALUOp=10, F3=111, F7=0000001:
  - Macro undefined -> Operation=1111, illegal=1.
  - Macro defined -> out_valid stays 0 and trap=1 next cycle.
- FULL state, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1; the flushed and incoming bundles never appear.
- Branch ALUOp=01, F3=110 -> 1010; F3=010 -> illegal handling per macro.
